// File: rtl/icache_loader.sv
// Instruction cache loader: packs a little-endian byte stream into 32-bit
// words, writes them to consecutive cache word addresses, and holds the core
// in reset until the whole image has been written.
module icache_loader #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [6:0]    nwords_i,
    input  logic [7:0]    byte_i,
    input  logic          byte_valid_i,
    output logic          byte_ready_o,
    output logic          wr_en_o,
    output logic [AW-1:0] wraddr_o,
    output logic [31:0]   wrdata_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          core_rst_o
);

    // Word count used when nwords_i is zero or larger than the cache.
    localparam logic [6:0] MaxWords = 7'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWrite,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [6:0]    word_cnt_q, word_cnt_d;
    logic [6:0]    target_q, target_d;
    logic [AW-1:0] wraddr_q, wraddr_d;
    logic [31:0]   wrdata_q, wrdata_d;
    logic [6:0]    word_cnt_inc;

    assign word_cnt_inc = word_cnt_q + 7'd1;

    // State and datapath registers; reset drops any in-flight write at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            byte_cnt_q <= 2'd0;
            word_cnt_q <= 7'd0;
            target_q   <= 7'd0;
            wraddr_q   <= '0;
            wrdata_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            target_q   <= target_d;
            wraddr_q   <= wraddr_d;
            wrdata_q   <= wrdata_d;
        end
    end

    // Next-state logic: start handling, byte-lane assembly and word sequencing.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        target_d   = target_q;
        wraddr_d   = wraddr_q;
        wrdata_d   = wrdata_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    target_d   = (nwords_i == 7'd0 || nwords_i > MaxWords) ? MaxWords : nwords_i;
                    wraddr_d   = '0;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = 7'd0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                if (byte_valid_i) begin
                    unique case (byte_cnt_q)
                        2'd0: wrdata_d[7:0]   = byte_i;
                        2'd1: wrdata_d[15:8]  = byte_i;
                        2'd2: wrdata_d[23:16] = byte_i;
                        2'd3: wrdata_d[31:24] = byte_i;
                        default: wrdata_d = wrdata_q;
                    endcase
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                word_cnt_d = word_cnt_inc;
                // Last word keeps its address so wraddr_o never passes target-1.
                if (word_cnt_inc == target_q) begin
                    state_d = StDone;
                end else begin
                    wraddr_d = wraddr_q + AW'(1);
                    state_d  = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        byte_ready_o = 1'b0;
        wr_en_o      = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        core_rst_o   = 1'b1;
        unique case (state_q)
            StIdle: ;
            StLoad: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
            end
            StWrite: begin
                wr_en_o = 1'b1;
                busy_o  = 1'b1;
            end
            StDone: begin
                done_o     = 1'b1;
                core_rst_o = 1'b0;
            end
            default: ;
        endcase
    end

    assign wraddr_o = wraddr_q;
    assign wrdata_o = wrdata_q;

endmodule

// File: tb/tb_icache_loader.sv
// Bench for icache_loader: a cycle-by-cycle vector table for a single-word
// load followed by a restart from DONE, then directed multi-word sequences.
module tb_icache_loader;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [6:0]  nwords_i = 7'd0;
    logic [7:0]  byte_i = 8'd0;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o;
    logic        wr_en_o;
    logic [5:0]  wraddr_o;
    logic [31:0] wrdata_o;
    logic        busy_o;
    logic        done_o;
    logic        core_rst_o;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [5:0]  wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];

    localparam logic [42:0] RstExp = 43'd1;

    icache_loader #(.DEPTH(64), .AW(6)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .nwords_i     (nwords_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .wr_en_o      (wr_en_o),
        .wraddr_o     (wraddr_o),
        .wrdata_o     (wrdata_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .core_rst_o   (core_rst_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Record every cache write seen by the fetch-side array.
    always @(negedge clk_i) begin
        if (wr_en_o === 1'b1) begin
            wq_addr.push_back(wraddr_o);
            wq_data.push_back(wrdata_o);
            wq_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic        start;
        logic [6:0]  nwords;
        logic [7:0]  b;
        logic        valid;
        logic        rdy;
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic        busy;
        logic        done;
        logic        crst;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic st, logic [6:0] nw, logic [7:0] b, logic v, logic rdy,
                                logic wr, logic [5:0] a, logic [31:0] d, logic bsy, logic dn,
                                logic cr);
        vec_t r;
        r.start = st; r.nwords = nw; r.b = b; r.valid = v;
        r.rdy = rdy; r.wr = wr; r.addr = a; r.data = d; r.busy = bsy; r.done = dn; r.crst = cr;
        return r;
    endfunction

    function automatic logic [42:0] exp_of(vec_t v);
        return {v.rdy, v.wr, v.addr, v.data, v.busy, v.done, v.crst};
    endfunction

    function automatic logic [42:0] obs();
        return {byte_ready_o, wr_en_o, wraddr_o, wrdata_o, busy_o, done_o, core_rst_o};
    endfunction

    function automatic logic [31:0] pat(int i, int s);
        return {8'(i), 8'(s), 8'(i * 3 + 1), 8'h5A};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic clear_q();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_i = 8'd0; nwords_i = 7'd0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic do_start(input logic [6:0] n);
        @(negedge clk_i);
        start_i = 1'b1; nwords_i = n;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Send nb bytes of w; optional stall of 'stall' idle cycles after byte 1.
    // Returns just after the posedge that accepted the last byte.
    task automatic send_word(input logic [31:0] w, input int stall, input int nb);
        int n;
        int bad;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk_i);
            byte_i = w[i*8 +: 8];
            byte_valid_i = 1'b1;
            n = 0;
            while (!byte_ready_o && n < 100) begin
                @(negedge clk_i);
                n++;
            end
            if (n >= 100) begin
                n_checks++;
                $display("FAIL accept_wait: waited %0d cycles, limit 100", n);
            end
            @(posedge clk_i);
            if (i == 1 && stall > 0) begin
                bad = 0;
                for (int k = 0; k < stall; k++) begin
                    @(negedge clk_i);
                    byte_valid_i = 1'b0;
                    if (byte_ready_o !== 1'b1 || wr_en_o !== 1'b0) bad++;
                end
                check("stall_ready_no_write", bad, 0);
            end
        end
    endtask

    task automatic idle_bytes();
        @(negedge clk_i);
        byte_valid_i = 1'b0;
    endtask

    // Full load of 'count' words; checks addresses, data, done timing, no extras.
    task automatic run_load(input string name, input logic [6:0] nw, input int count,
                            input int seed);
        int bad;
        clear_q();
        do_start(nw);
        for (int i = 0; i < count; i++) send_word(pat(i, seed), 0, 4);
        idle_bytes();
        check({name, "_done_low_in_write"}, done_o, 0);
        @(negedge clk_i);
        check({name, "_done"}, {done_o, core_rst_o, busy_o}, 3'b100);
        check({name, "_nwrites"}, wq_addr.size(), count);
        bad = 0;
        for (int i = 0; i < wq_addr.size() && i < count; i++) begin
            if (wq_addr[i] !== 6'(i) || wq_data[i] !== pat(i, seed)) bad++;
        end
        check({name, "_addr_data_errors"}, bad, 0);
        repeat (10) @(negedge clk_i);
        check({name, "_no_extra_writes"}, wq_addr.size(), count);
    endtask

    initial begin
        int bad;

        vecs[0]  = mk(1, 1, 8'h00, 0, 0, 0, 0, 32'h00000000, 0, 0, 1);
        vecs[1]  = mk(0, 0, 8'h00, 0, 1, 0, 0, 32'h00000000, 1, 0, 1);
        vecs[2]  = mk(0, 0, 8'h13, 1, 1, 0, 0, 32'h00000000, 1, 0, 1);
        vecs[3]  = mk(0, 0, 8'h05, 1, 1, 0, 0, 32'h00000013, 1, 0, 1);
        vecs[4]  = mk(0, 0, 8'h50, 1, 1, 0, 0, 32'h00000513, 1, 0, 1);
        vecs[5]  = mk(0, 0, 8'h00, 1, 1, 0, 0, 32'h00500513, 1, 0, 1);
        vecs[6]  = mk(0, 0, 8'hFF, 1, 0, 1, 0, 32'h00500513, 1, 0, 1);
        vecs[7]  = mk(1, 2, 8'hEE, 1, 0, 0, 0, 32'h00500513, 0, 1, 0);
        vecs[8]  = mk(0, 0, 8'h11, 1, 1, 0, 0, 32'h00500513, 1, 0, 1);
        vecs[9]  = mk(0, 0, 8'h22, 1, 1, 0, 0, 32'h00500511, 1, 0, 1);
        vecs[10] = mk(0, 0, 8'h33, 1, 1, 0, 0, 32'h00502211, 1, 0, 1);
        vecs[11] = mk(0, 0, 8'h44, 1, 1, 0, 0, 32'h00332211, 1, 0, 1);
        vecs[12] = mk(1, 5, 8'h99, 0, 0, 1, 0, 32'h44332211, 1, 0, 1);
        vecs[13] = mk(0, 0, 8'hAA, 1, 1, 0, 1, 32'h44332211, 1, 0, 1);
        vecs[14] = mk(0, 0, 8'hBB, 1, 1, 0, 1, 32'h443322AA, 1, 0, 1);
        vecs[15] = mk(0, 0, 8'hCC, 1, 1, 0, 1, 32'h4433BBAA, 1, 0, 1);
        vecs[16] = mk(0, 0, 8'hDD, 1, 1, 0, 1, 32'h44CCBBAA, 1, 0, 1);
        vecs[17] = mk(0, 0, 8'h00, 0, 0, 1, 1, 32'hDDCCBBAA, 1, 0, 1);
        vecs[18] = mk(0, 0, 8'h00, 0, 0, 0, 1, 32'hDDCCBBAA, 0, 1, 0);
        vecs[19] = mk(0, 0, 8'h00, 0, 0, 0, 1, 32'hDDCCBBAA, 0, 1, 0);

        // Reset values, while reset is held and after release.
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("reset_held", obs(), RstExp);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("reset_released", obs(), RstExp);

        // Single word 0x00500513, then restart from DONE with two words.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            start_i = vecs[k].start;
            nwords_i = vecs[k].nwords;
            byte_i = vecs[k].b;
            byte_valid_i = vecs[k].valid;
            check($sformatf("vec%0d", k), obs(), exp_of(vecs[k]));
        end
        start_i = 1'b0;
        byte_valid_i = 1'b0;

        // Three words back to back at 5-cycle spacing.
        do_reset();
        run_load("three", 7'd3, 3, 1);
        bad = 0;
        for (int i = 1; i < wq_cyc.size(); i++) if (wq_cyc[i] - wq_cyc[i-1] != 5) bad++;
        check("three_spacing_errors", bad, 0);

        // Stalled source between bytes 2 and 3.
        do_reset();
        clear_q();
        do_start(7'd1);
        send_word(32'hCAFE0197, 7, 4);
        idle_bytes();
        @(negedge clk_i);
        check("stall_nwrites", wq_addr.size(), 1);
        if (wq_data.size() > 0) check("stall_word", {wq_addr[0], wq_data[0]}, {6'd0, 32'hCAFE0197});
        check("stall_done", done_o, 1);

        // Count clamping to 64.
        do_reset();
        run_load("clamp0", 7'd0, 64, 2);
        do_reset();
        run_load("clamp100", 7'd100, 64, 3);

        // Asynchronous reset after two bytes of the first word.
        do_reset();
        clear_q();
        do_start(7'd2);
        send_word(32'h12345678, 0, 2);
        @(negedge clk_i);
        byte_valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1 check("async_rst_outputs", obs(), RstExp);
        @(negedge clk_i);
        rst_i = 1'b0;
        check("async_rst_no_write", wq_addr.size(), 0);
        run_load("after_rst", 7'd1, 1, 9);

        // Reset landing in the write cycle cancels the strobe.
        do_reset();
        clear_q();
        do_start(7'd2);
        send_word(32'h0BADF00D, 0, 4);
        #1 check("write_cycle_wr_en", wr_en_o, 1);
        #1 rst_i = 1'b1;
        #1 check("write_cancelled", obs(), RstExp);
        @(negedge clk_i);
        rst_i = 1'b0;
        byte_valid_i = 1'b0;
        check("write_cancelled_none", wq_addr.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1);
    end

endmodule
